esp32_prog_seq: RTL

- Front-end stage for the ESP32 programming passthru.
- Synchronises and deglitches the FTDI DTR/RTS modem lines.
- Decodes them into clean EN/IO0 drive levels.
- Tracks the esptool auto-reset handshake with an FSM, producing a programming-start pulse and a programming-active window. The passthru uses these for EN/IO0 drive and for releasing the SD/bootstrap lines.

---
 rtl/esp32_prog_seq.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/esp32_prog_seq.sv
// rtl/esp32_prog_seq.sv - ESP32 programming front-end: DTR/RTS sync, deglitch, decode, auto-reset FSM
//
// Ports:
//   clk_25mhz    in   system clock
//   reset        in   asynchronous, active-high reset
//   ftdi_ndtr    in   raw DTR# from the FTDI (asynchronous)
//   ftdi_nrts    in   raw RTS# from the FTDI (asynchronous)
//   dtr_n_clean  out  synchronised, filtered DTR#
//   rts_n_clean  out  synchronised, filtered RTS#
//   esp_en       out  EN drive level (0 holds the ESP32 in reset)
//   esp_gpio0    out  IO0 drive level (0 selects download boot)
//   prog_start   out  one-cycle pulse on a valid boot-select
//   prog_active  out  high while a programming session is in progress
//   seq_state    out  FSM state (00 IDLE, 01 RST_HELD, 10 BOOT_SEL, 11 PROG)

module esp32_prog_seq #(
   parameter int C_filter_cycles   = 250,
   parameter int C_seq_timeout     = 22,
   parameter int C_release_timeout = 26
) (
   input  logic       clk_25mhz,
   input  logic       reset,
   input  logic       ftdi_ndtr,
   input  logic       ftdi_nrts,
   output logic       dtr_n_clean,
   output logic       rts_n_clean,
   output logic       esp_en,
   output logic       esp_gpio0,
   output logic       prog_start,
   output logic       prog_active,
   output logic [1:0] seq_state
);

   localparam int                 C_cnt_w   = $clog2(C_filter_cycles + 1);
   localparam logic [C_cnt_w-1:0] C_cnt_max = C_cnt_w'(C_filter_cycles);

   typedef enum logic [1:0] {
      S_IDLE     = 2'b00,
      S_RST_HELD = 2'b01,
      S_BOOT_SEL = 2'b10,
      S_PROG     = 2'b11
   } state_t;

   // Bit 1 carries DTR#, bit 0 carries RTS#, so clean_q is directly P.
   logic [1:0]                   sync1_q, sync1_d;
   logic [1:0]                   sync2_q, sync2_d;
   logic [1:0]                   clean_q, clean_d;
   logic [1:0][C_cnt_w-1:0]      cnt_q, cnt_d;
   logic                         en_q, en_d;
   logic                         gpio0_q, gpio0_d;
   state_t                       state_q, state_d;
   logic                         from_prog_q, from_prog_d;
   logic [C_seq_timeout-1:0]     seq_tmr_q, seq_tmr_d;
   logic [C_release_timeout-1:0] rel_tmr_q, rel_tmr_d;
   logic                         prog_start_q, prog_start_d;
   logic                         prog_active_q, prog_active_d;

   always_comb begin
      sync1_d = {ftdi_ndtr, ftdi_nrts};
      sync2_d = sync1_q;
      clean_d = clean_q;
      cnt_d   = '0;
      // The counter must sit at C_filter_cycles with the line still
      // different before the clean value flips; any matching cycle restarts it.
      for (int i = 0; i < 2; i++) begin
         if (sync2_q[i] != clean_q[i]) begin
            if (cnt_q[i] == C_cnt_max) begin
               clean_d[i] = ~clean_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
      en_d    = (clean_q != 2'b10);
      gpio0_d = (clean_q != 2'b01);
   end

   always_comb begin
      state_d      = state_q;
      from_prog_d  = from_prog_q;
      seq_tmr_d    = seq_tmr_q;
      rel_tmr_d    = rel_tmr_q;
      prog_start_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (clean_q == 2'b10) begin
               state_d     = S_RST_HELD;
               seq_tmr_d   = '0;
               from_prog_d = 1'b0;
            end
         end
         S_RST_HELD: begin
            if (clean_q == 2'b01) begin
               state_d      = S_BOOT_SEL;
               prog_start_d = 1'b1;
            end else if (clean_q == 2'b11) begin
               state_d = S_IDLE;
            end else if (seq_tmr_q == '1) begin
               state_d = S_IDLE;
            end else begin
               seq_tmr_d = seq_tmr_q + 1'b1;
            end
         end
         S_BOOT_SEL: begin
            if (clean_q == 2'b11 || clean_q == 2'b00) begin
               state_d   = S_PROG;
               rel_tmr_d = '0;
            end else if (clean_q == 2'b10) begin
               state_d     = S_RST_HELD;
               from_prog_d = 1'b1;
               seq_tmr_d   = '0;
            end
         end
         S_PROG: begin
            // A re-sync reset wins over the release timeout.
            if (clean_q == 2'b10) begin
               state_d     = S_RST_HELD;
               from_prog_d = 1'b1;
               seq_tmr_d   = '0;
            end else if (rel_tmr_q == '1) begin
               state_d = S_IDLE;
            end else begin
               rel_tmr_d = rel_tmr_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Derived from the next state so prog_active lines up with seq_state.
      prog_active_d = (state_d == S_BOOT_SEL) || (state_d == S_PROG) ||
                      ((state_d == S_RST_HELD) && from_prog_d);
   end

   always_ff @(posedge clk_25mhz or posedge reset) begin
      if (reset) begin
         sync1_q       <= 2'b11;
         sync2_q       <= 2'b11;
         clean_q       <= 2'b11;
         cnt_q         <= '0;
         en_q          <= 1'b1;
         gpio0_q       <= 1'b1;
         state_q       <= S_IDLE;
         from_prog_q   <= 1'b0;
         seq_tmr_q     <= '0;
         rel_tmr_q     <= '0;
         prog_start_q  <= 1'b0;
         prog_active_q <= 1'b0;
      end else begin
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         clean_q       <= clean_d;
         cnt_q         <= cnt_d;
         en_q          <= en_d;
         gpio0_q       <= gpio0_d;
         state_q       <= state_d;
         from_prog_q   <= from_prog_d;
         seq_tmr_q     <= seq_tmr_d;
         rel_tmr_q     <= rel_tmr_d;
         prog_start_q  <= prog_start_d;
         prog_active_q <= prog_active_d;
      end
   end

   assign dtr_n_clean = clean_q[1];
   assign rts_n_clean = clean_q[0];
   assign esp_en      = en_q;
   assign esp_gpio0   = gpio0_q;
   assign prog_start  = prog_start_q;
   assign prog_active = prog_active_q;
   assign seq_state   = state_q;

endmodule
